pulse_sync_s2f: RTL and testbench

PULSE_SYNC_S2F -- requirements
Module: pulse_sync_s2f

---
 rtl/pulse_sync_s2f_pkg.sv | 22 ++
 rtl/pulse_sync_s2f_if.sv | 36 +++
 rtl/pulse_sync_s2f_sync_ff.sv | 29 ++
 rtl/pulse_sync_s2f.sv | 108 ++++++++++
 tb/tb_pulse_sync_s2f.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_sync_s2f_pkg.sv
// Shared constants and helpers for the slow-to-fast pulse synchroniser.
//   DEF_SYNC_STAGES / DEF_CNT_W : default parameter values
//   clamp_stages()              : folds a requested chain depth into the legal 2..4 range
package pulse_sync_s2f_pkg;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;

    // A chain shorter than two flops would not give metastability time to settle.
    function automatic int unsigned clamp_stages(input int unsigned stages);
        if (stages < MIN_SYNC_STAGES) begin
            return MIN_SYNC_STAGES;
        end
        if (stages > MAX_SYNC_STAGES) begin
            return MAX_SYNC_STAGES;
        end
        return stages;
    endfunction

endpackage

// File: rtl/pulse_sync_s2f_if.sv
// Signal bundle for pulse_sync_s2f.
//   clk_slow domain : data_in (event in), busy (transfer in flight), drop_cnt (rejected events)
//   clk_fast domain : cnt_clr (clear pulse_cnt), pulse_out (delivered pulse), pulse_cnt (delivered count)
//   master drives events/clear, slave is the synchroniser.
interface pulse_sync_s2f_if
    import pulse_sync_s2f_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             data_in;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;
    logic             cnt_clr;
    logic             pulse_out;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output data_in,
        output cnt_clr,
        input  busy,
        input  drop_cnt,
        input  pulse_out,
        input  pulse_cnt
    );

    modport slave (
        input  data_in,
        input  cnt_clr,
        output busy,
        output drop_cnt,
        output pulse_out,
        output pulse_cnt
    );

endinterface

// File: rtl/pulse_sync_s2f_sync_ff.sv
// Plain multi-flop synchroniser chain (module sync_ff).
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into every stage
//   d     : asynchronous input
//   q     : synchronised output, STAGES edges after d settles
module sync_ff #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* async_reg = "true" *) logic [STAGES-1:0] sync_q;

    // Pure shift chain: nothing between stages so each flop gets a full period to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_sync_s2f.sv
// Toggle/ack pulse synchroniser from clk_slow to clk_fast (works for any clock ratio).
//   clk_fast : destination clock (pulse_out, pulse_cnt, cnt_clr)
//   clk_slow : source clock (data_in, busy, drop_cnt)
//   rst_n    : asynchronous active-low reset for both domains
//   bus      : pulse_sync_s2f_if.slave, see interface for signal domains
// One event is accepted per round trip; events arriving while busy are counted as drops.
module pulse_sync_s2f
    import pulse_sync_s2f_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk_fast,
    input  logic             clk_slow,
    input  logic             rst_n,
    pulse_sync_s2f_if.slave  bus
);

    localparam int unsigned      STAGES  = clamp_stages(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             req_tog;
    logic             ack_sync;
    logic             busy_c;
    logic             accept_c;
    logic [CNT_W-1:0] drop_q;

    logic             req_sync;
    logic             req_d;
    logic             pulse_c;
    logic [CNT_W-1:0] pulse_cnt_q;

    // ---------------- clk_slow domain ----------------

    // Outstanding request whenever the returned ack has not caught up with req_tog.
    assign busy_c   = req_tog ^ ack_sync;
    assign accept_c = bus.data_in & ~busy_c;

    // Request toggle: one flip per accepted event.
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            req_tog <= 1'b0;
        end else if (accept_c) begin
            req_tog <= ~req_tog;
        end
    end

    // Saturating count of events that arrived while a transfer was in flight.
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (bus.data_in && busy_c && (drop_q != CNT_MAX)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    // Ack toggle returns from the fast side.
    sync_ff #(
        .STAGES  (STAGES),
        .RST_VAL (1'b0)
    ) u_ack_sync (
        .clk   (clk_slow),
        .rst_n (rst_n),
        .d     (req_d),
        .q     (ack_sync)
    );

    // ---------------- clk_fast domain ----------------

    sync_ff #(
        .STAGES  (STAGES),
        .RST_VAL (1'b0)
    ) u_req_sync (
        .clk   (clk_fast),
        .rst_n (rst_n),
        .d     (req_tog),
        .q     (req_sync)
    );

    // req_d doubles as the ack toggle sent back to clk_slow.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            req_d <= 1'b0;
        end else begin
            req_d <= req_sync;
        end
    end

    // Edge detect on the synchronised toggle: exactly one cycle per flip.
    assign pulse_c = req_sync ^ req_d;

    // Delivered-pulse counter; a clear coinciding with a pulse leaves that pulse counted.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            pulse_cnt_q <= CNT_W'(pulse_c);
        end else if (pulse_c && (pulse_cnt_q != CNT_MAX)) begin
            pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
        end
    end

    assign bus.busy      = busy_c;
    assign bus.drop_cnt  = drop_q;
    assign bus.pulse_out = pulse_c;
    assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_sync_s2f.sv
// Self-checking bench for pulse_sync_s2f: three instances (default, CNT_W=3, SYNC_STAGES=3),
// table-driven spaced-event vectors plus directed multi-cycle sequences.
module tb_pulse_sync_s2f;

    logic clk_fast;
    logic clk_slow;
    logic rst_n;

    int unsigned hp_slow = 50;
    int unsigned hp_fast = 20;
    bit          jitter  = 1'b0;

    int errors = 0;
    int checks = 0;

    int   mon_a = 0;
    int   mon_b = 0;
    int   mon_c = 0;
    int   dups  = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic prev_c = 1'b0;

    typedef struct {
        int unsigned n_ev;
        int unsigned gap;
        bit          clr_first;
        int          exp_pcnt;
        int          exp_dcnt;
    } vec_t;

    vec_t vecs [5];
    int   m0;
    int   lat;
    bit   found;
    int   g;

    pulse_sync_s2f_if #(.CNT_W(8))  bus_a ();
    pulse_sync_s2f_if #(.CNT_W(3))  bus_b ();
    pulse_sync_s2f_if #(.CNT_W(16)) bus_c ();

    pulse_sync_s2f #(.SYNC_STAGES(2), .CNT_W(8)) dut_a (
        .clk_fast (clk_fast), .clk_slow (clk_slow), .rst_n (rst_n), .bus (bus_a));
    pulse_sync_s2f #(.SYNC_STAGES(2), .CNT_W(3)) dut_b (
        .clk_fast (clk_fast), .clk_slow (clk_slow), .rst_n (rst_n), .bus (bus_b));
    pulse_sync_s2f #(.SYNC_STAGES(3), .CNT_W(16)) dut_c (
        .clk_fast (clk_fast), .clk_slow (clk_slow), .rst_n (rst_n), .bus (bus_c));

    // Fast clock offset by 5 ticks so its edges never coincide with slow edges at nominal rates.
    initial begin
        clk_slow = 1'b0;
        forever begin
            #(hp_slow + (jitter ? $urandom_range(0, 6) : 0));
            clk_slow = ~clk_slow;
        end
    end

    initial begin
        clk_fast = 1'b0;
        #5;
        forever begin
            clk_fast = ~clk_fast;
            #(hp_fast + (jitter ? $urandom_range(0, 6) : 0));
        end
    end

    // Independent pulse counters and back-to-back pulse detector.
    always @(negedge clk_fast) begin
        if (bus_a.pulse_out) begin mon_a++; if (prev_a) dups++; end
        if (bus_b.pulse_out) begin mon_b++; if (prev_b) dups++; end
        if (bus_c.pulse_out) begin mon_c++; if (prev_c) dups++; end
        prev_a = bus_a.pulse_out;
        prev_b = bus_b.pulse_out;
        prev_c = bus_c.pulse_out;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_data(input int d, input logic v);
        case (d)
            0:       bus_a.data_in = v;
            1:       bus_b.data_in = v;
            default: bus_c.data_in = v;
        endcase
    endtask

    task automatic set_clr(input int d, input logic v);
        case (d)
            0:       bus_a.cnt_clr = v;
            1:       bus_b.cnt_clr = v;
            default: bus_c.cnt_clr = v;
        endcase
    endtask

    task automatic send_event(input int d, input int gap);
        @(negedge clk_slow);
        set_data(d, 1'b1);
        @(negedge clk_slow);
        set_data(d, 1'b0);
        repeat (gap) @(negedge clk_slow);
    endtask

    task automatic do_clear(input int d);
        @(negedge clk_fast);
        set_clr(d, 1'b1);
        @(negedge clk_fast);
        set_clr(d, 1'b0);
    endtask

    task automatic burst(input int d, input int k);
        @(negedge clk_slow);
        set_data(d, 1'b1);
        repeat (k) @(negedge clk_slow);
        set_data(d, 1'b0);
    endtask

    initial begin
        vecs[0] = '{n_ev: 1, gap: 20, clr_first: 1'b1, exp_pcnt: 1, exp_dcnt: 0};
        vecs[1] = '{n_ev: 3, gap: 20, clr_first: 1'b0, exp_pcnt: 4, exp_dcnt: 0};
        vecs[2] = '{n_ev: 5, gap: 15, clr_first: 1'b1, exp_pcnt: 5, exp_dcnt: 0};
        vecs[3] = '{n_ev: 0, gap: 20, clr_first: 1'b1, exp_pcnt: 0, exp_dcnt: 0};
        vecs[4] = '{n_ev: 2, gap: 12, clr_first: 1'b0, exp_pcnt: 2, exp_dcnt: 0};

        rst_n = 1'b0;
        bus_a.data_in = 1'b0; bus_a.cnt_clr = 1'b0;
        bus_b.data_in = 1'b0; bus_b.cnt_clr = 1'b0;
        bus_c.data_in = 1'b0; bus_c.cnt_clr = 1'b0;
        repeat (3) @(negedge clk_slow);

        // Reset state
        check("reset a.pulse_cnt", int'(bus_a.pulse_cnt), 0);
        check("reset a.drop_cnt",  int'(bus_a.drop_cnt), 0);
        check("reset a.busy",      int'(bus_a.busy), 0);
        check("reset a.pulse_out", int'(bus_a.pulse_out), 0);
        check("reset b.pulse_cnt", int'(bus_b.pulse_cnt), 0);
        check("reset c.drop_cnt",  int'(bus_c.drop_cnt), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_slow);

        // Table of spaced-event vectors on the default instance
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].clr_first) do_clear(0);
            m0 = mon_a;
            for (int e = 0; e < int'(vecs[i].n_ev); e++) send_event(0, int'(vecs[i].gap));
            repeat (10) @(negedge clk_slow);
            check($sformatf("vec%0d pulse_cnt", i), int'(bus_a.pulse_cnt), vecs[i].exp_pcnt);
            check($sformatf("vec%0d drop_cnt", i),  int'(bus_a.drop_cnt), vecs[i].exp_dcnt);
            check($sformatf("vec%0d busy", i),      int'(bus_a.busy), 0);
            check($sformatf("vec%0d pulses", i),    mon_a - m0, int'(vecs[i].n_ev));
        end

        // Single event: busy at accept edge, pulse two fast edges later
        do_clear(0);
        @(negedge clk_slow);
        bus_a.data_in = 1'b1;
        @(posedge clk_slow);
        #1;
        check("single busy at accept", int'(bus_a.busy), 1);
        fork
            begin @(negedge clk_slow); bus_a.data_in = 1'b0; end
        join_none
        lat = 0;
        found = 1'b0;
        while (!found && lat < 20) begin
            @(posedge clk_fast);
            #1;
            lat++;
            if (bus_a.pulse_out) found = 1'b1;
        end
        check_rng("single pulse latency", lat, 2, 3);
        repeat (20) @(negedge clk_slow);
        check("single pulse_cnt", int'(bus_a.pulse_cnt), 1);
        check("single busy clear", int'(bus_a.busy), 0);
        check("single drop_cnt",   int'(bus_a.drop_cnt), 0);

        // data_in held for 10 slow cycles
        do_clear(0);
        m0 = mon_a;
        burst(0, 10);
        repeat (15) @(negedge clk_slow);
        check("burst10 total", int'(bus_a.pulse_cnt) + int'(bus_a.drop_cnt), 10);
        check_rng("burst10 accepted", int'(bus_a.pulse_cnt), 2, 5);
        check("burst10 pulses seen", mon_a - m0, int'(bus_a.pulse_cnt));

        // Reset in the middle of a transfer
        @(negedge clk_slow);
        bus_a.data_in = 1'b1;
        @(posedge clk_slow);
        #1;
        check("midrst busy before", int'(bus_a.busy), 1);
        rst_n = 1'b0;
        bus_a.data_in = 1'b0;
        #1;
        check("midrst busy in reset",      int'(bus_a.busy), 0);
        check("midrst pulse_out in reset", int'(bus_a.pulse_out), 0);
        check("midrst pulse_cnt in reset", int'(bus_a.pulse_cnt), 0);
        check("midrst drop_cnt in reset",  int'(bus_a.drop_cnt), 0);
        repeat (3) @(negedge clk_slow);
        rst_n = 1'b1;
        m0 = mon_a;
        repeat (30) @(negedge clk_slow);
        check("midrst no pulse after", mon_a - m0, 0);
        check("midrst busy after",     int'(bus_a.busy), 0);
        check("midrst pulse_cnt after", int'(bus_a.pulse_cnt), 0);
        check("midrst drop_cnt after",  int'(bus_a.drop_cnt), 0);

        // CNT_W=3 saturation
        m0 = mon_b;
        for (int e = 0; e < 9; e++) send_event(1, 20);
        repeat (10) @(negedge clk_slow);
        check("sat pulse_cnt", int'(bus_b.pulse_cnt), 7);
        check("sat pulses seen", mon_b - m0, 9);
        check("sat drop_cnt", int'(bus_b.drop_cnt), 0);

        // Clear coinciding with a pulse leaves pulse_cnt at 1
        @(negedge clk_slow);
        bus_b.data_in = 1'b1;
        fork
            begin @(negedge clk_slow); bus_b.data_in = 1'b0; end
        join_none
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_fast);
            if (bus_b.pulse_out) found = 1'b1;
        end
        check("coincident pulse seen", int'(found), 1);
        bus_b.cnt_clr = 1'b1;
        @(negedge clk_fast);
        bus_b.cnt_clr = 1'b0;
        check("coincident clr pulse_cnt", int'(bus_b.pulse_cnt), 1);
        repeat (20) @(negedge clk_slow);
        check("coincident pulse_cnt hold", int'(bus_b.pulse_cnt), 1);

        // drop_cnt saturation
        burst(1, 40);
        repeat (15) @(negedge clk_slow);
        check("drop sat drop_cnt", int'(bus_b.drop_cnt), 7);

        // Fast clock slower than slow clock (40 MHz vs 100 MHz)
        hp_fast = 125;
        repeat (5) @(negedge clk_slow);
        do_clear(0);
        m0 = mon_a;
        for (int e = 0; e < 20; e++) send_event(0, 30);
        repeat (30) @(negedge clk_slow);
        check("swap pulse_cnt", int'(bus_a.pulse_cnt), 20);
        check("swap pulses seen", mon_a - m0, 20);
        check("swap drop_cnt", int'(bus_a.drop_cnt), 0);
        hp_fast = 20;
        repeat (5) @(negedge clk_slow);

        // SYNC_STAGES=3 with jittered clocks, 1000 random events
        jitter = 1'b1;
        m0 = mon_c;
        for (int e = 0; e < 1000; e++) begin
            @(negedge clk_slow);
            bus_c.data_in = 1'b1;
            g = int'($urandom_range(0, 4));
            if (g > 0) begin
                @(negedge clk_slow);
                bus_c.data_in = 1'b0;
                repeat (g - 1) @(negedge clk_slow);
            end
        end
        @(negedge clk_slow);
        bus_c.data_in = 1'b0;
        repeat (40) @(negedge clk_slow);
        jitter = 1'b0;
        check("random total", int'(bus_c.pulse_cnt) + int'(bus_c.drop_cnt), 1000);
        check("random pulses seen", mon_c - m0, int'(bus_c.pulse_cnt));
        check("random busy clear", int'(bus_c.busy), 0);

        check("no back-to-back pulses", dups, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
